cordic_vectoring: RTL and testbench

- Iterative vectoring-mode CORDIC. Drives y of an input vector (x, y) toward zero and accumulates the rotation angle, producing atan2(y, x) and the gain-scaled magnitude.
- Inverse companion to the combinational rotation-mode iteration stages: those take an angle and produce a vector; this block takes a vector and produces an angle.
- Sequential: one micro-rotation per clock, one internal shift/add datapath, valid/ready handshakes on input and output. Used for phase and magnitude recovery.

---
 rtl/cordic_vectoring.sv | 161 ++++++++++++++++
 tb/tb_cordic_vectoring.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: rotates (x, y) onto the +x axis one micro-rotation per clock,
// producing atan2(y, x) and the gain-scaled magnitude behind valid/ready handshakes.
module cordic_vectoring #(
  parameter int unsigned FRAC_BITS  = 20,
  parameter int unsigned ITERATIONS = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [FRAC_BITS+1:0] x_in,
  input  logic signed [FRAC_BITS+1:0] y_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [FRAC_BITS+3:0] mag_out,
  output logic signed [FRAC_BITS+2:0] angle_out
);

  localparam int unsigned IW = FRAC_BITS + 2;
  localparam int unsigned XW = FRAC_BITS + 4;
  localparam int unsigned ZW = FRAC_BITS + 3;
  localparam int unsigned CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

  // pi/4 with 62 fractional bits; every angle constant is derived from this scale.
  localparam longint unsigned Pi4Q62 = 64'h3243_F6A8_885A_308D;

  function automatic longint unsigned to_frac(input longint unsigned q62);
    return (q62 + (64'd1 << (61 - FRAC_BITS))) >> (62 - FRAC_BITS);
  endfunction

  // atan(2^-i) in Q62 by its power series; only evaluated at elaboration.
  function automatic longint unsigned atan_q62(input int unsigned i);
    longint unsigned acc;
    longint unsigned term;
    int unsigned     sh;
    int unsigned     k;
    if (i == 0) return Pi4Q62;
    acc = '0;
    k   = 0;
    sh  = i;
    while (sh < 62) begin
      term = (64'd1 << (62 - sh)) / 64'(2 * k + 1);
      if (k[0]) acc = acc - term;
      else      acc = acc + term;
      k  = k + 1;
      sh = sh + 2 * i;
    end
    return acc;
  endfunction

  localparam logic signed [ZW-1:0] Pi2 = ZW'(to_frac(Pi4Q62 << 1));

  logic signed [ZW-1:0] atan_tab [ITERATIONS];

  for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
    localparam longint unsigned AtanVal = to_frac(atan_q62(g));
    assign atan_tab[g] = ZW'(AtanVal);
  end

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic signed [XW-1:0] x_q, y_q;
  logic signed [ZW-1:0] z_q;
  logic                 out_valid_q;
  logic signed [XW-1:0] mag_q;
  logic signed [ZW-1:0] angle_q;

  logic signed [XW-1:0] x_in_ext, y_in_ext;
  logic signed [XW-1:0] x_cap, y_cap;
  logic signed [ZW-1:0] z_cap;
  logic signed [XW-1:0] x_sh, y_sh;
  logic signed [XW-1:0] x_d, y_d;
  logic signed [ZW-1:0] z_d;

  // Quadrant pre-rotation by +/-pi/2 so the iterations only need to cover |angle| <= pi/2.
  always_comb begin
    x_in_ext = {{2{x_in[IW-1]}}, x_in};
    y_in_ext = {{2{y_in[IW-1]}}, y_in};
    x_cap    = x_in_ext;
    y_cap    = y_in_ext;
    z_cap    = '0;
    if (x_in[IW-1]) begin
      if (!y_in[IW-1]) begin
        x_cap = y_in_ext;
        y_cap = -x_in_ext;
        z_cap = Pi2;
      end else begin
        x_cap = -y_in_ext;
        y_cap = x_in_ext;
        z_cap = -Pi2;
      end
    end
  end

  always_comb begin
    x_sh = x_q >>> cnt_q;
    y_sh = y_q >>> cnt_q;
    if (!y_q[XW-1]) begin
      x_d = x_q + y_sh;
      y_d = y_q - x_sh;
      z_d = z_q + atan_tab[cnt_q];
    end else begin
      x_d = x_q - y_sh;
      y_d = y_q + x_sh;
      z_d = z_q - atan_tab[cnt_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
      mag_q       <= '0;
      angle_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            x_q     <= x_cap;
            y_q     <= y_cap;
            z_q     <= z_cap;
            cnt_q   <= '0;
            state_q <= StIter;
          end
        end
        StIter: begin
          x_q   <= x_d;
          y_q   <= y_d;
          z_q   <= z_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(ITERATIONS - 1)) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            mag_q       <= x_d;
            angle_q     <= z_d;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Held low while reset is asserted so nothing is offered during the reset cycle.
  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = out_valid_q;
  assign mag_out   = mag_q;
  assign angle_out = angle_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Self-checking bench for cordic_vectoring: directed vectors, backpressure, mid-run reset and a
// back-to-back random stream against an integer reference model plus float tolerance checks.
module tb_cordic_vectoring;

  localparam int  F   = 20;
  localparam int  N   = 20;
  localparam int  IW  = F + 2;
  localparam real PiR = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] x_in;
  logic [IW-1:0] y_in;
  logic          out_valid;
  logic          out_ready;
  logic [F+3:0]  mag_out;
  logic [F+2:0]  angle_out;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint atan_tab [N];
  longint pi2;
  real    gain;

  cordic_vectoring #(.FRAC_BITS(F), .ITERATIONS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag_out   (mag_out),
    .angle_out (angle_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic init_model();
    gain = 1.0;
    for (int i = 0; i < N; i++) begin
      atan_tab[i] = longint'($rtoi($atan(1.0 / (2.0 ** i)) * (2.0 ** F) + 0.5));
      gain = gain * $sqrt(1.0 + 2.0 ** (-2 * i));
    end
    pi2 = longint'($rtoi(PiR / 2.0 * (2.0 ** F) + 0.5));
  endtask

  task automatic golden(input longint xi, input longint yi, output longint mag, output longint ang);
    longint x, y, z, xn, yn;
    if (xi >= 0) begin
      x = xi; y = yi; z = 0;
    end else if (yi >= 0) begin
      x = yi; y = -xi; z = pi2;
    end else begin
      x = -yi; y = xi; z = -pi2;
    end
    for (int i = 0; i < N; i++) begin
      if (y >= 0) begin
        xn = x + (y >>> i); yn = y - (x >>> i); z = z + atan_tab[i];
      end else begin
        xn = x - (y >>> i); yn = y + (x >>> i); z = z - atan_tab[i];
      end
      x = xn;
      y = yn;
    end
    mag = x;
    ang = z;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; y_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (mag_out !== '0) begin n_fail++; $display("FAIL reset_mag: got %h want 0", mag_out); end
    n_checks++;
    if (angle_out !== '0) begin n_fail++; $display("FAIL reset_angle: got %h want 0", angle_out); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    longint vx [7] = '{64'sh100000, 0, 64'sh100000, -64'sh100000, -64'sh100000, -64'sh100000, 0};
    longint vy [7] = '{0, 64'sh100000, 64'sh100000, 0, -1, -64'sh100000, 0};
    for (int v = 0; v < 7; v++) begin
      longint em, ea, gm, ga;
      int     lat;
      real    ia, im, da, dm;
      golden(vx[v], vy[v], em, ea);
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL directed_in_ready[%0d]: got %b want 1", v, in_ready); end
      x_in = IW'(vx[v]); y_in = IW'(vy[v]); in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < N + 10) begin @(negedge clk); lat++; end
      n_checks++;
      if (lat != N) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d want %0d", v, lat, N); end
      gm = longint'($signed(mag_out));
      ga = longint'($signed(angle_out));
      n_checks++;
      if (gm != em) begin n_fail++; $display("FAIL directed_mag[%0d]: got %0d want %0d", v, gm, em); end
      n_checks++;
      if (ga != ea) begin n_fail++; $display("FAIL directed_angle[%0d]: got %0d want %0d", v, ga, ea); end
      if (v < 6) begin
        ia = $atan2(real'(vy[v]), real'(vx[v])) * (2.0 ** F);
        im = gain * $sqrt(real'(vx[v]) * real'(vx[v]) + real'(vy[v]) * real'(vy[v]));
        da = real'(ga) - ia; if (da < 0.0) da = -da;
        dm = real'(gm) - im; if (dm < 0.0) dm = -dm;
        n_checks++;
        if (da > real'(N + 4)) begin
          n_fail++; $display("FAIL directed_angle_float[%0d]: got %0d want %f", v, ga, ia);
        end
        n_checks++;
        if (dm > 64.0) begin
          n_fail++; $display("FAIL directed_mag_float[%0d]: got %0d want %f", v, gm, im);
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL directed_release[%0d]: got valid=%b ready=%b want 0/1", v, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    longint em, ea;
    int     lat;
    golden(64'sh0C0000, -64'sh050000, em, ea);
    out_ready = 1'b0;
    @(negedge clk);
    x_in = IW'(64'sh0C0000); y_in = IW'(-64'sh050000); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < N + 10) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat != N) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", lat, N); end
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      x_in = IW'(64'sh050000); y_in = IW'(64'sh010000);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", k, out_valid); end
      n_checks++;
      if (longint'($signed(mag_out)) != em) begin
        n_fail++; $display("FAIL bp_mag[%0d]: got %0d want %0d", k, $signed(mag_out), em);
      end
      n_checks++;
      if (longint'($signed(angle_out)) != ea) begin
        n_fail++; $display("FAIL bp_angle[%0d]: got %0d want %0d", k, $signed(angle_out), ea);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    repeat (N + 3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_input: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    longint em, ea;
    int     lat;
    @(negedge clk);
    x_in = IW'(64'sh0A0000); y_in = IW'(64'sh030000); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    n_checks++;
    if (mag_out !== '0 || angle_out !== '0) begin
      n_fail++; $display("FAIL midrst_outputs: got mag=%h angle=%h want 0/0", mag_out, angle_out);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    golden(64'sh100000, 0, em, ea);
    @(negedge clk);
    x_in = IW'(64'sh100000); y_in = '0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < N + 10) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat != N) begin n_fail++; $display("FAIL midrst_latency: got %0d want %0d", lat, N); end
    n_checks++;
    if (longint'($signed(mag_out)) != em || longint'($signed(angle_out)) != ea) begin
      n_fail++;
      $display("FAIL midrst_result: got mag=%0d angle=%0d want %0d/%0d",
               $signed(mag_out), $signed(angle_out), em, ea);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    longint        vx [100];
    longint        vy [100];
    longint        exp_m [$];
    longint        exp_a [$];
    longint        em, ea;
    logic [IW-1:0] t;
    int            sent = 0;
    int            got = 0;
    int            cycles = 0;
    bit            in_hs;
    for (int i = 0; i < 100; i++) begin
      t = IW'($urandom); vx[i] = longint'($signed(t));
      t = IW'($urandom); vy[i] = longint'($signed(t));
    end
    vx[0] = -(64'sd1 <<< (F + 1)); vy[0] = -(64'sd1 <<< (F + 1));
    vx[1] = (64'sd1 <<< (F + 1)) - 1; vy[1] = (64'sd1 <<< (F + 1)) - 1;
    vx[2] = -(64'sd1 <<< (F + 1)); vy[2] = 0;
    @(negedge clk);
    x_in = IW'(vx[0]); y_in = IW'(vy[0]); in_valid = 1'b1; out_ready = 1'b1;
    while (got < 100 && cycles < 100 * (N + 2) + 200) begin
      if (out_valid === 1'b1) begin
        if (exp_m.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b2b_unexpected_result: got mag=%0d want no result", $signed(mag_out));
        end else begin
          em = exp_m.pop_front();
          ea = exp_a.pop_front();
          n_checks++;
          if (longint'($signed(mag_out)) != em) begin
            n_fail++; $display("FAIL b2b_mag[%0d]: got %0d want %0d", got, $signed(mag_out), em);
          end
          n_checks++;
          if (longint'($signed(angle_out)) != ea) begin
            n_fail++; $display("FAIL b2b_angle[%0d]: got %0d want %0d", got, $signed(angle_out), ea);
          end
        end
        got++;
      end
      in_hs = (in_valid === 1'b1) && (in_ready === 1'b1);
      if (in_hs) begin
        golden(vx[sent], vy[sent], em, ea);
        exp_m.push_back(em);
        exp_a.push_back(ea);
        sent++;
      end
      @(posedge clk);
      #1;
      if (in_hs) begin
        if (sent < 100) begin
          x_in = IW'(vx[sent]); y_in = IW'(vy[sent]);
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (got != 100 || sent != 100) begin
      n_fail++; $display("FAIL b2b_count: got results=%0d accepted=%0d want 100/100", got, sent);
    end
    n_checks++;
    if (exp_m.size() != 0) begin
      n_fail++; $display("FAIL b2b_leftover: got %0d pending want 0", exp_m.size());
    end
  endtask

  initial begin
    init_model();
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
